// File: rtl/merge_port_arbiter.sv
// rtl/merge_port_arbiter.sv - packet-locked round-robin merge of NPORT flit streams into one registered output
// A port owns the output from its head flit through its tail flit; rr_ptr rotates priority per packet.
module merge_port_arbiter #(
   parameter int               DW         = 32,
   parameter int               NPORT      = 5,
   parameter logic [NPORT-1:0] INPUT_MASK = '1,
   parameter int               TAIL_BIT   = DW-1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NPORT-1:0][DW-1:0]   data_i,
   input  logic [NPORT-1:0]           valid_i,
   output logic [NPORT-1:0]           ready_o,
   output logic [DW-1:0]              data_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [NPORT-1:0]           grant_o,
   output logic                       busy_o
);

   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    owner;
   logic [PW-1:0]    win_idx;
   logic [NPORT-1:0] req;
   logic             win_found;
   logic             accept;
   logic             tail;

   // Circular search starting one past the last owner.
   always_comb begin : pick
      int j;
      j         = 0;
      req       = valid_i & INPUT_MASK;
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 1; i <= NPORT; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= NPORT) j = j - NPORT;
         if (!win_found && req[j]) begin
            win_found = 1'b1;
            win_idx   = PW'(j);
         end
      end
   end

   always_comb begin : ctrl
      state_nxt = state;
      ready_o   = '0;
      accept    = 1'b0;
      tail      = 1'b0;
      case (state)
         IDLE: begin
            if (win_found) state_nxt = LOCK;
         end
         LOCK: begin
            ready_o[owner] = (!valid_o || ready_i) && INPUT_MASK[owner];
            accept         = valid_i[owner] && ready_o[owner];
            tail           = accept && data_i[owner][TAIL_BIT];
            if (tail) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rr_ptr  <= PW'(NPORT-1);
         owner   <= '0;
         grant_o <= '0;
         data_o  <= '0;
         valid_o <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && win_found) begin
            owner   <= win_idx;
            grant_o <= NPORT'(1) << win_idx;
         end
         if (tail) begin
            rr_ptr  <= owner;
            grant_o <= '0;
         end
         // Output register: load on accept, drain on downstream ready, otherwise hold.
         if (accept) begin
            data_o  <= data_i[owner];
            valid_o <= 1'b1;
         end else if (ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

   assign busy_o = (state == LOCK);

endmodule

// File: tb/tb_merge_port_arbiter.sv
// tb/tb_merge_port_arbiter.sv - directed vector bench for merge_port_arbiter
// Table rows cover single-port, backpressure and contention; hand sequences cover mask, reset and gaps.
module tb_merge_port_arbiter;

   localparam int DW    = 32;
   localparam int NPORT = 5;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [NPORT-1:0][DW-1:0] data_i;
   logic [NPORT-1:0]         valid_i;
   logic                     ready_i;
   logic [NPORT-1:0]         ready_o, ready_m;
   logic [DW-1:0]            data_o, data_m;
   logic                     valid_o, valid_m;
   logic [NPORT-1:0]         grant_o, grant_m;
   logic                     busy_o, busy_m;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   merge_port_arbiter #(.DW(DW), .NPORT(NPORT)) dut (
      .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .grant_o(grant_o), .busy_o(busy_o)
   );

   merge_port_arbiter #(.DW(DW), .NPORT(NPORT), .INPUT_MASK(5'b11101)) dut_m (
      .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_m),
      .data_o(data_m), .valid_o(valid_m), .ready_i(ready_i), .grant_o(grant_m), .busy_o(busy_m)
   );

   typedef struct {
      logic [4:0]  v;
      logic [31:0] d;
      logic        sep;
      logic        rdy;
      logic [4:0]  eg;
      logic        eb;
      logic [4:0]  er;
      logic        ev;
      logic [31:0] ed;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [4:0] v, input logic [31:0] d, input logic sep,
                               input logic rdy, input logic [4:0] eg, input logic eb,
                               input logic [4:0] er, input logic ev, input logic [31:0] ed);
      vec_t r;
      r.v = v; r.d = d; r.sep = sep; r.rdy = rdy;
      r.eg = eg; r.eb = eb; r.er = er; r.ev = ev; r.ed = ed;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // sep=1 tags each port's flit with its index in bits [15:8].
   task automatic drive(input logic [4:0] v, input logic [31:0] d, input logic sep, input logic rdy);
      valid_i = v;
      ready_i = rdy;
      for (int p = 0; p < NPORT; p++)
         data_i[p] = sep ? (d | (32'(p) << 8)) : d;
   endtask

   task automatic cyc(input logic [4:0] v, input logic [31:0] d);
      @(negedge clk);
      drive(v, d, 1'b0, 1'b1);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive('0, '0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset grant", 32'(grant_o), 32'd0);
      chk("reset busy", 32'(busy_o), 32'd0);
      chk("reset valid_o", 32'(valid_o), 32'd0);
      chk("reset data_o", data_o, 32'd0);
      chk("reset ready_o", 32'(ready_o), 32'd0);
      chk("reset mask grant", 32'(grant_m), 32'd0);
      chk("reset mask valid_o", 32'(valid_m), 32'd0);
   endtask

   initial begin
      drive('0, '0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);

      // Single port: port 2, three flits.
      tbl.push_back(mk(5'b00100, 32'h11,       0, 1, 5'b00000, 0, 5'b00000, 0, 32'h0));
      tbl.push_back(mk(5'b00100, 32'h11,       0, 1, 5'b00100, 1, 5'b00100, 0, 32'h0));
      tbl.push_back(mk(5'b00100, 32'h22,       0, 1, 5'b00100, 1, 5'b00100, 1, 32'h11));
      tbl.push_back(mk(5'b00100, 32'h80000033, 0, 1, 5'b00100, 1, 5'b00100, 1, 32'h22));
      tbl.push_back(mk(5'b00000, 32'h0,        0, 1, 5'b00000, 0, 5'b00000, 1, 32'h80000033));
      tbl.push_back(mk(5'b00000, 32'h0,        0, 1, 5'b00000, 0, 5'b00000, 0, 32'h80000033));
      // Backpressure: port 3, four flits, ready_i low for four cycles.
      tbl.push_back(mk(5'b01000, 32'hA1,       0, 1, 5'b00000, 0, 5'b00000, 0, 32'h80000033));
      tbl.push_back(mk(5'b01000, 32'hA1,       0, 1, 5'b01000, 1, 5'b01000, 0, 32'h80000033));
      tbl.push_back(mk(5'b01000, 32'hA2,       0, 1, 5'b01000, 1, 5'b01000, 1, 32'hA1));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(5'b01000, 32'hA3,    0, 0, 5'b01000, 1, 5'b00000, 1, 32'hA2));
      tbl.push_back(mk(5'b01000, 32'hA3,       0, 1, 5'b01000, 1, 5'b01000, 1, 32'hA2));
      tbl.push_back(mk(5'b01000, 32'h800000A4, 0, 1, 5'b01000, 1, 5'b01000, 1, 32'hA3));
      tbl.push_back(mk(5'b00000, 32'h0,        0, 1, 5'b00000, 0, 5'b00000, 1, 32'h800000A4));
      tbl.push_back(mk(5'b00000, 32'h0,        0, 1, 5'b00000, 0, 5'b00000, 0, 32'h800000A4));
      // Contention: ports 0,1,3 single-flit packets; port 0 keeps requesting.
      tbl.push_back(mk(5'b01011, 32'h80000000, 1, 1, 5'b00000, 0, 5'b00000, 0, 32'h800000A4));
      tbl.push_back(mk(5'b01011, 32'h80000000, 1, 1, 5'b00001, 1, 5'b00001, 0, 32'h800000A4));
      tbl.push_back(mk(5'b01011, 32'h80000000, 1, 1, 5'b00000, 0, 5'b00000, 1, 32'h80000000));
      tbl.push_back(mk(5'b01011, 32'h80000000, 1, 1, 5'b00010, 1, 5'b00010, 0, 32'h80000000));
      tbl.push_back(mk(5'b01001, 32'h80000000, 1, 1, 5'b00000, 0, 5'b00000, 1, 32'h80000100));
      tbl.push_back(mk(5'b01001, 32'h80000000, 1, 1, 5'b01000, 1, 5'b01000, 0, 32'h80000100));
      tbl.push_back(mk(5'b00001, 32'h80000000, 1, 1, 5'b00000, 0, 5'b00000, 1, 32'h80000300));
      tbl.push_back(mk(5'b00001, 32'h80000000, 1, 1, 5'b00001, 1, 5'b00001, 0, 32'h80000300));
      tbl.push_back(mk(5'b00000, 32'h0,        0, 1, 5'b00000, 0, 5'b00000, 1, 32'h80000000));
      tbl.push_back(mk(5'b00000, 32'h0,        0, 1, 5'b00000, 0, 5'b00000, 0, 32'h80000000));

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i].v, tbl[i].d, tbl[i].sep, tbl[i].rdy);
         #1;
         chk($sformatf("row%0d grant", i),   32'(grant_o), 32'(tbl[i].eg));
         chk($sformatf("row%0d busy", i),    32'(busy_o),  32'(tbl[i].eb));
         chk($sformatf("row%0d ready_o", i), 32'(ready_o), 32'(tbl[i].er));
         chk($sformatf("row%0d valid_o", i), 32'(valid_o), 32'(tbl[i].ev));
         chk($sformatf("row%0d data_o", i),  data_o,       tbl[i].ed);
      end

      // Masked port 1 requesting continuously.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cyc(5'b00010, 32'h80000005);
         chk($sformatf("mask%0d grant", k),   32'(grant_m), 32'd0);
         chk($sformatf("mask%0d ready_o", k), 32'(ready_m), 32'd0);
         chk($sformatf("mask%0d valid_o", k), 32'(valid_m), 32'd0);
      end

      // Reset after the 2nd of 4 flits from port 0.
      do_reset();
      cyc(5'b00001, 32'h1);
      chk("rstpkt idle grant", 32'(grant_o), 32'd0);
      cyc(5'b00001, 32'h1);
      chk("rstpkt grant", 32'(grant_o), 32'b00001);
      cyc(5'b00001, 32'h2);
      chk("rstpkt flit1", data_o, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      drive(5'b00001, 32'h3, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      drive(5'b10001, 32'h3, 1'b0, 1'b1);
      #1;
      chk("rstpkt valid_o", 32'(valid_o), 32'd0);
      chk("rstpkt grant cleared", 32'(grant_o), 32'd0);
      chk("rstpkt busy", 32'(busy_o), 32'd0);
      chk("rstpkt ready_o", 32'(ready_o), 32'd0);
      cyc(5'b10001, 32'h3);
      chk("rstpkt port0 first", 32'(grant_o), 32'b00001);
      chk("rstpkt no partial", 32'(valid_o), 32'd0);

      // Gapped owner: port 2 pauses while port 4 requests.
      do_reset();
      cyc(5'b00100, 32'h21);
      chk("gap idle", 32'(grant_o), 32'd0);
      cyc(5'b00100, 32'h21);
      chk("gap grant", 32'(grant_o), 32'b00100);
      for (int k = 0; k < 3; k++) begin
         cyc(5'b10000, 32'h0);
         chk($sformatf("gap%0d grant held", k), 32'(grant_o), 32'b00100);
         chk($sformatf("gap%0d busy", k),       32'(busy_o),  32'd1);
         chk($sformatf("gap%0d ready_o", k),    32'(ready_o), 32'b00100);
         chk($sformatf("gap%0d valid_o", k),    32'(valid_o), (k == 0) ? 32'd1 : 32'd0);
      end
      cyc(5'b10100, 32'h80000022);
      chk("gap tail grant", 32'(grant_o), 32'b00100);
      cyc(5'b10000, 32'h0);
      chk("gap after tail grant", 32'(grant_o), 32'd0);
      chk("gap tail data", data_o, 32'h80000022);
      chk("gap tail valid", 32'(valid_o), 32'd1);
      cyc(5'b10000, 32'h80000044);
      chk("gap port4 grant", 32'(grant_o), 32'b10000);
      cyc(5'b00000, 32'h0);
      chk("gap port4 data", data_o, 32'h80000044);
      chk("gap port4 released", 32'(grant_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/merge_port_arbiter.md
MERGE_PORT_ARBITER -- requirements
Module: merge_port_arbiter

Interface
REQ-001 Parameter DW, default 32: flit width in bits.
REQ-002 Parameter NPORT, default 5: requester count; port 0 local, ports 1-4 neighbour directions.
REQ-003 Parameter INPUT_MASK, default all-ones (NPORT bits): a 1 marks a port as eligible for arbitration.
REQ-004 Parameter TAIL_BIT, default DW-1: flit bit index that marks the last flit of a packet.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port data_i, input, NPORT x DW: requester flits.
REQ-008 Port valid_i, input, NPORT: requester flit valid.
REQ-009 Port ready_o, output, NPORT: flit accepted when valid_i[p] && ready_o[p].
REQ-010 Port data_o, output, DW: merged output flit, registered.
REQ-011 Port valid_o, output, 1: output flit valid, registered.
REQ-012 Port ready_i, input, 1: downstream accepts when valid_o && ready_i.
REQ-013 Port grant_o, output, NPORT: one-hot current packet owner; all-zero when idle.
REQ-014 Port busy_o, output, 1: high while in LOCK.

Function
REQ-015 Two-state FSM (IDLE, LOCK) plus a rr_ptr register of width clog2(NPORT).
REQ-016 IDLE: request vector = valid_i & INPUT_MASK.
- Winner = first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NPORT.
- On a nonzero request vector: register grant_o = one-hot winner and go to LOCK.
- No flit is accepted in the IDLE cycle.
REQ-017 In IDLE, all ready_o are 0.
REQ-018 In LOCK, ready_o[owner] = !valid_o || ready_i; all other ready_o are 0.
REQ-019 In LOCK, an accepted flit is loaded into data_o with valid_o=1 on the next edge. Latency: input accept to data_o is 1 cycle.
REQ-020 When valid_o && ready_i and no new flit is accepted in the same cycle, valid_o clears next cycle.
REQ-021 While valid_o && !ready_i, data_o and valid_o are held stable.
REQ-022 Throughput while locked, with the owner streaming and ready_i constantly high: one flit per cycle.
REQ-023 On acceptance of a flit with data_i[owner][TAIL_BIT]=1:
- FSM returns to IDLE next cycle.
- rr_ptr <= owner index; grant_o clears.
- The tail flit still drains through the output register normally.
REQ-024 A single-flit packet (tail set on the head flit) holds LOCK for exactly one accepted flit.
REQ-025 If the owner drops valid_i mid-packet, the FSM stays in LOCK, with no timeout and no re-arbitration.
REQ-026 Masked ports (INPUT_MASK bit 0) are never granted; their ready_o is constantly 0.
REQ-027 Tail accept in the same cycle as other ports requesting: exactly one IDLE cycle follows before the next grant.
REQ-028 rr_ptr wraps from NPORT-1 to 0; the search order is strictly circular.
REQ-029 Packet start latency: valid_i rise (port idle, no contention) to first data_o valid is 2 cycles.

Reset
REQ-030 While rst=1 at a clock edge, all of the following hold on the next cycle:
- state IDLE;
- rr_ptr = NPORT-1, so port 0 has first priority;
- valid_o = 0, data_o = 0, grant_o = 0, busy_o = 0;
- ready_o = 0.
REQ-031 Reset mid-packet abandons the packet; no partial flit is emitted after reset deasserts.

Verification
REQ-032 Single port:
- Stimulus: after reset, port 2 sends 3 flits (tail on 3rd), data 0x11, 0x22, 0x80000033; ready_i=1.
- Required: grant_o=5'b00100 from cycle 1; data_o 0x11, 0x22, 0x80000033 in cycles 2-4; IDLE in cycle 4.
REQ-033 Contention:
- Stimulus: ports 0, 1, 3 each hold a pending 1-flit packet.
- Required: grant order 0, 1, 3; each grant separated by one IDLE cycle.
- Stimulus: port 0 requests again afterwards.
- Required: port 0 is granted only after port 3.
REQ-034 Backpressure:
- Stimulus: ready_i=0 for 4 cycles mid-packet.
- Required: data_o is held stable; owner ready_o=0 after the first stalled flit; no flit is lost or duplicated.
REQ-035 Mask:
- Stimulus: INPUT_MASK=5'b11101 and port 1 valid continuously.
- Required: no grant, ready_o[1]=0, valid_o stays 0.
REQ-036 Reset mid-packet:
- Stimulus: assert rst after the 2nd of 4 flits.
- Required: next cycle has valid_o=0, grant_o=0, state IDLE; rr_ptr=4, so port 0 is granted first.
REQ-037 Gapped owner:
- Stimulus: the owner deasserts valid_i for 3 cycles mid-packet while port 4 requests.
- Required: the lock is held; port 4 is granted only after the owner's tail flit.
